timgen_seq: RTL and testbench
=============================

Name: timgen_seq

Overview:
- Capture sequencer sitting between the CPU register interface and the CCD/AFE timing generator, in the clk_pix domain.
- Turns a CPU capture command into a series of trigger pulses: first FLUSH dummy readouts to clear the CCD, then N real frames.
- Supervises each readout: counts hsync lines, enforces a cycle timeout and issues a timing-generator reset on abort or error.
- Reports per-frame status and raises an interrupt.

Parameters:
- FLUSH, default 1: dummy readouts before the first real frame; 0 disables flushing.
- LINE_W, default 12: width of the line counters.
- TO_W, default 24: width of the timeout counter.
- RST_HOLD, default 4: number of cycles tg_rst is held after an abort or error.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- cmd_start  in  1  one-cycle pulse; starts a capture; ignored unless busy=0
- cmd_abort  in  1  one-cycle pulse; aborts the capture in progress
- cmd_frames  in  8  real frame count, sampled at start; 0 is treated as 1
- cmd_lines  in  LINE_W  expected hsync count per readout, sampled at start
- cmd_timeout  in  TO_W  maximum cycles per readout, sampled at start
- tg_done  in  1  timing generator done (level)
- tg_hsync  in  1  line sync from the timing generator
- tg_trigger  out  1  one-cycle trigger pulse to the timing generator
- tg_rst  out  1  reset to the timing generator
- busy  out  1  high while not IDLE
- frame_valid  out  1  one-cycle pulse when a real frame completes cleanly
- frame_idx  out  8  index of the last completed real frame, counting from 0
- line_cnt  out  LINE_W  hsync count of the last readout
- err_lines  out  1  sticky; set on line-count mismatch
- err_timeout  out  1  sticky; set on timeout
- irq  out  1  one-cycle pulse at the end of a capture: complete, abort or error

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Counters, latched command values and sticky flags are all cleared.
- Edge detection: tg_done and tg_hsync are registered once each. A rising edge is the current sample high and the previous sample low. All reactions therefore occur 1 cycle after the input edge.
- IDLE:
  - cmd_start clears err_lines and err_timeout, latches the cmd_* inputs, loads flush_left=FLUSH and frames_left=max(cmd_frames,1), and sets busy on the next cycle.
  - If FLUSH>0 the next state is TRIG with flush flag=1; otherwise TRIG with flush flag=0.
- TRIG: tg_trigger=1 for exactly this cycle. Clears hsync_cnt and to_cnt. Next state is WAIT.
- WAIT:
  - to_cnt increments every cycle; hsync_cnt increments on each hsync rising edge and saturates at all-ones.
  - On a tg_done rising edge the next state is CHECK.
  - If to_cnt reaches cmd_timeout-1 with no done edge, err_timeout is set and the next state is RECOV.
  - If the done edge and the timeout occur in the same cycle, done wins.
- CHECK (1 cycle):
  - line_cnt <= hsync_cnt.
  - Flush readout: the line count is not checked. flush_left decrements. When it reaches 0 the flush flag clears. Next state is TRIG.
  - Real readout with hsync_cnt != cmd_lines: err_lines is set and the next state is RECOV.
  - Real readout with a matching count: frame_valid pulses and frame_idx <= frame number (0-based), then frames_left decrements. If frames_left was 1, the next state is DONE; otherwise TRIG.
- RECOV: tg_rst=1 for RST_HOLD cycles, then the next state is DONE.
- DONE: irq pulses for 1 cycle; busy=0 from the next cycle; the next state is IDLE.
- Abort:
  - cmd_abort in TRIG, WAIT or CHECK goes to RECOV next cycle. It overrides any same-cycle done edge, so no frame_valid is generated. No error flag is set.
  - cmd_abort in IDLE, RECOV or DONE is ignored.
  - cmd_start while busy is ignored.
- Handshake: there is never more than one outstanding trigger; a trigger is only issued from TRIG, after the previous done edge has been seen.
- Mid-operation rst: the FSM returns immediately to IDLE and tg_rst deasserts. The timing generator is reset by the same rst.
- Width rules: cmd_timeout=0 is treated as 1, so the timeout fires at the first WAIT cycle. frame_idx wraps modulo 256, which cannot occur because cmd_frames is at most 255.

Test Plan:
- FLUSH=1, cmd_frames=2, cmd_lines=8; model emits 8 hsyncs then done per trigger -> exactly 3 tg_trigger pulses; frame_valid twice with frame_idx 0 then 1; irq once; no error flags; busy deasserted 2 cycles after the last done edge.
- Flush readout emits 5 lines, real readouts emit 8 -> no err_lines; line_cnt reads 5 after the flush CHECK and 8 at the end.
- Real readout emits 7 lines -> err_lines=1; tg_rst high for 4 cycles; irq pulses; frame_valid never pulses; no further trigger.
- cmd_timeout=100 and the model never asserts done -> err_timeout set 100 cycles after TRIG; RECOV entered, then irq.
- cmd_abort 20 cycles into WAIT, and separately cmd_abort on the same cycle as a done edge -> both go to RECOV; no frame_valid; no error flags; irq pulses.
- cmd_start while busy, cmd_frames=0, and rst asserted mid-WAIT -> the second start is ignored; frames=0 captures exactly 1 frame; rst returns all outputs to 0 on the next cycle.

Source files
------------

// File: rtl/timgen_seq.sv
// Capture sequencer between the CPU register block and the CCD/AFE timing generator.
// Issues flush readouts, then real frames, supervising line count and readout timeout.
module timgen_seq #(
   parameter int FLUSH    = 1,
   parameter int LINE_W   = 12,
   parameter int TO_W     = 24,
   parameter int RST_HOLD = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_start_i,
   input  logic              cmd_abort_i,
   input  logic [7:0]        cmd_frames_i,
   input  logic [LINE_W-1:0] cmd_lines_i,
   input  logic [TO_W-1:0]   cmd_timeout_i,
   input  logic              tg_done_i,
   input  logic              tg_hsync_i,
   output logic              tg_trigger_o,
   output logic              tg_rst_o,
   output logic              busy_o,
   output logic              frame_valid_o,
   output logic [7:0]        frame_idx_o,
   output logic [LINE_W-1:0] line_cnt_o,
   output logic              err_lines_o,
   output logic              err_timeout_o,
   output logic              irq_o
);

   localparam logic [7:0] FLUSH_INIT = 8'(FLUSH);
   localparam logic       FLUSH_EN   = (FLUSH > 0) ? 1'b1 : 1'b0;
   localparam logic [7:0] HOLD_LAST  = (RST_HOLD > 1) ? 8'(RST_HOLD - 1) : 8'd0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_TRIG  = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_RECOV = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state_q;
   logic              done_q;
   logic              hsync_q;
   logic [LINE_W-1:0] lines_q;
   logic [LINE_W-1:0] hsync_cnt_q;
   logic [LINE_W-1:0] hsync_cnt_d;
   logic [LINE_W-1:0] line_cnt_q;
   logic [TO_W-1:0]   to_lim_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic [7:0]        flush_left_q;
   logic [7:0]        frames_left_q;
   logic [7:0]        frame_num_q;
   logic [7:0]        frame_idx_q;
   logic [7:0]        hold_cnt_q;
   logic              flush_q;
   logic              tg_trigger_q;
   logic              tg_rst_q;
   logic              busy_q;
   logic              frame_valid_q;
   logic              err_lines_q;
   logic              err_timeout_q;
   logic              irq_q;
   logic              done_rise_s;
   logic              hsync_rise_s;
   logic              timeout_hit_s;

   assign done_rise_s   = tg_done_i & ~done_q;
   assign hsync_rise_s  = tg_hsync_i & ~hsync_q;
   assign timeout_hit_s = (to_cnt_q == (to_lim_q - TO_W'(1)));

   // Saturating hsync counter next value
   always_comb begin
      hsync_cnt_d = hsync_cnt_q;
      if (hsync_rise_s && (hsync_cnt_q != {LINE_W{1'b1}})) begin
         hsync_cnt_d = hsync_cnt_q + LINE_W'(1);
      end else begin
         hsync_cnt_d = hsync_cnt_q;
      end
   end

   // Sequencer FSM with registered outputs; abort and errors funnel through RECOV
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         done_q        <= 1'b0;
         hsync_q       <= 1'b0;
         lines_q       <= {LINE_W{1'b0}};
         hsync_cnt_q   <= {LINE_W{1'b0}};
         line_cnt_q    <= {LINE_W{1'b0}};
         to_lim_q      <= {TO_W{1'b0}};
         to_cnt_q      <= {TO_W{1'b0}};
         flush_left_q  <= 8'd0;
         frames_left_q <= 8'd0;
         frame_num_q   <= 8'd0;
         frame_idx_q   <= 8'd0;
         hold_cnt_q    <= 8'd0;
         flush_q       <= 1'b0;
         tg_trigger_q  <= 1'b0;
         tg_rst_q      <= 1'b0;
         busy_q        <= 1'b0;
         frame_valid_q <= 1'b0;
         err_lines_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         done_q        <= tg_done_i;
         hsync_q       <= tg_hsync_i;
         tg_trigger_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         irq_q         <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tg_rst_q <= 1'b0;
               if (cmd_start_i) begin
                  err_lines_q   <= 1'b0;
                  err_timeout_q <= 1'b0;
                  lines_q       <= cmd_lines_i;
                  to_lim_q      <= (cmd_timeout_i == {TO_W{1'b0}}) ? TO_W'(1) : cmd_timeout_i;
                  flush_left_q  <= FLUSH_INIT;
                  frames_left_q <= (cmd_frames_i == 8'd0) ? 8'd1 : cmd_frames_i;
                  frame_num_q   <= 8'd0;
                  flush_q       <= FLUSH_EN;
                  busy_q        <= 1'b1;
                  tg_trigger_q  <= 1'b1;
                  state_q       <= S_TRIG;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            S_TRIG: begin
               hsync_cnt_q <= {LINE_W{1'b0}};
               to_cnt_q    <= {TO_W{1'b0}};
               if (cmd_abort_i) begin
                  tg_rst_q   <= 1'b1;
                  hold_cnt_q <= 8'd0;
                  state_q    <= S_RECOV;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               hsync_cnt_q <= hsync_cnt_d;
               to_cnt_q    <= to_cnt_q + TO_W'(1);
               // priority: abort, then done edge, then timeout
               if (cmd_abort_i) begin
                  tg_rst_q   <= 1'b1;
                  hold_cnt_q <= 8'd0;
                  state_q    <= S_RECOV;
               end else if (done_rise_s) begin
                  state_q <= S_CHECK;
               end else if (timeout_hit_s) begin
                  err_timeout_q <= 1'b1;
                  tg_rst_q      <= 1'b1;
                  hold_cnt_q    <= 8'd0;
                  state_q       <= S_RECOV;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_CHECK: begin
               if (cmd_abort_i) begin
                  tg_rst_q   <= 1'b1;
                  hold_cnt_q <= 8'd0;
                  state_q    <= S_RECOV;
               end else begin
                  line_cnt_q <= hsync_cnt_q;
                  if (flush_q) begin
                     flush_left_q <= flush_left_q - 8'd1;
                     flush_q      <= (flush_left_q != 8'd1);
                     tg_trigger_q <= 1'b1;
                     state_q      <= S_TRIG;
                  end else if (hsync_cnt_q != lines_q) begin
                     err_lines_q <= 1'b1;
                     tg_rst_q    <= 1'b1;
                     hold_cnt_q  <= 8'd0;
                     state_q     <= S_RECOV;
                  end else begin
                     frame_valid_q <= 1'b1;
                     frame_idx_q   <= frame_num_q;
                     frame_num_q   <= frame_num_q + 8'd1;
                     frames_left_q <= frames_left_q - 8'd1;
                     if (frames_left_q == 8'd1) begin
                        irq_q   <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        tg_trigger_q <= 1'b1;
                        state_q      <= S_TRIG;
                     end
                  end
               end
            end
            S_RECOV: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  tg_rst_q <= 1'b0;
                  irq_q    <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  tg_rst_q   <= 1'b1;
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q   <= 1'b0;
               tg_rst_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign tg_trigger_o  = tg_trigger_q;
   assign tg_rst_o      = tg_rst_q;
   assign busy_o        = busy_q;
   assign frame_valid_o = frame_valid_q;
   assign frame_idx_o   = frame_idx_q;
   assign line_cnt_o    = line_cnt_q;
   assign err_lines_o   = err_lines_q;
   assign err_timeout_o = err_timeout_q;
   assign irq_o         = irq_q;

endmodule

// File: tb/tb_timgen_seq.sv
// Bench for timgen_seq: a timing-generator responder plays a per-readout plan, and a
// readout-level model predicts triggers, frames, errors and recovery for each capture.
module tb_timgen_seq;
   localparam int FLUSH    = 1;
   localparam int LINE_W   = 12;
   localparam int TO_W     = 24;
   localparam int RST_HOLD = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_start, cmd_abort;
   logic [7:0]        cmd_frames;
   logic [LINE_W-1:0] cmd_lines;
   logic [TO_W-1:0]   cmd_timeout;
   logic              tg_done, tg_hsync;
   logic              tg_trigger_o, tg_rst_o, busy_o, frame_valid_o;
   logic [7:0]        frame_idx_o;
   logic [LINE_W-1:0] line_cnt_o;
   logic              err_lines_o, err_timeout_o, irq_o;
   logic [26:0]       all_out;

   int tests = 0;
   int fails = 0;
   int plan_lines[16];
   bit plan_done[16];
   int rsp_idx = 0;
   bit rsp_kill = 1'b0;
   int m_line = 0;
   int m_idx = 0;

   timgen_seq #(.FLUSH(FLUSH), .LINE_W(LINE_W), .TO_W(TO_W), .RST_HOLD(RST_HOLD)) dut (
      .clk_i(clk), .rst_i(rst), .cmd_start_i(cmd_start), .cmd_abort_i(cmd_abort),
      .cmd_frames_i(cmd_frames), .cmd_lines_i(cmd_lines), .cmd_timeout_i(cmd_timeout),
      .tg_done_i(tg_done), .tg_hsync_i(tg_hsync), .tg_trigger_o(tg_trigger_o),
      .tg_rst_o(tg_rst_o), .busy_o(busy_o), .frame_valid_o(frame_valid_o),
      .frame_idx_o(frame_idx_o), .line_cnt_o(line_cnt_o), .err_lines_o(err_lines_o),
      .err_timeout_o(err_timeout_o), .irq_o(irq_o)
   );

   assign all_out = {tg_trigger_o, tg_rst_o, busy_o, frame_valid_o, frame_idx_o,
                     line_cnt_o, err_lines_o, err_timeout_o, irq_o};

   // Pixel clock
   always #5 clk = ~clk;

   // Timing generator: per trigger, L one-cycle hsync pulses then a 2-cycle done level
   initial begin
      int  hs_left;
      int  done_hold;
      bit  active;
      bit  hs_phase;
      bit  want_done;
      tg_done = 1'b0; tg_hsync = 1'b0;
      hs_left = 0; done_hold = 0; active = 1'b0; hs_phase = 1'b0; want_done = 1'b0;
      forever begin
         @(negedge clk);
         tg_hsync = 1'b0;
         if (done_hold > 0) begin
            done_hold--;
            if (done_hold == 0) tg_done = 1'b0;
         end
         if (rsp_kill || tg_rst_o) begin
            active = 1'b0; tg_done = 1'b0; done_hold = 0;
         end else if (tg_trigger_o) begin
            active = 1'b1; hs_phase = 1'b0;
            hs_left   = (rsp_idx < 16) ? plan_lines[rsp_idx] : 3;
            want_done = (rsp_idx < 16) ? plan_done[rsp_idx] : 1'b1;
            rsp_idx++;
         end else if (active) begin
            if (hs_left > 0) begin
               if (!hs_phase) begin
                  tg_hsync = 1'b1;
                  hs_left--;
               end
               hs_phase = !hs_phase;
            end else begin
               if (want_done) begin
                  tg_done = 1'b1;
                  done_hold = 2;
               end
               active = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_plan(input int a, input int b, input int c);
      for (int i = 0; i < 16; i++) begin
         plan_lines[i] = 3;
         plan_done[i]  = 1'b1;
      end
      plan_lines[0] = a; plan_lines[1] = b; plan_lines[2] = c;
   endtask

   // Readout-level reference: a readout of L lines ends its wait after 2L cycles.
   task automatic predict(input int frames, input int lines, input int timeout,
                          input int amode, input int ard,
                          output int e_trig, output int e_valid, output int e_el,
                          output int e_et, output int e_abort, output int e_clean);
      int n_rd;
      int tl;
      n_rd = FLUSH + ((frames == 0) ? 1 : frames);
      tl = (timeout == 0) ? 1 : timeout;
      e_trig = 0; e_valid = 0; e_el = 0; e_et = 0; e_abort = 0; e_clean = 0;
      for (int i = 0; i < n_rd; i++) begin
         e_trig++;
         if (amode != 0 && i == ard) begin
            e_abort = 1;
            break;
         end
         if (!plan_done[i] || (2 * plan_lines[i] > tl)) begin
            e_et = 1;
            break;
         end
         m_line = plan_lines[i];
         if (i >= FLUSH) begin
            if (plan_lines[i] != lines) begin
               e_el = 1;
               break;
            end
            m_idx = e_valid;
            e_valid++;
         end
         if (i == n_rd - 1) e_clean = 1;
      end
   endtask

   // One capture: amode 1 aborts 20 cycles into readout ard's wait, amode 2 on its done edge
   task automatic run(input int frames, input int lines, input int timeout,
                      input int amode, input int ard, input bit restart);
      int e_trig, e_valid, e_el, e_et, e_abort, e_clean;
      int trig, valid, rstc, irqc, since, trig_smp, et_smp, done_smp, busy_fall;
      bit seen_busy, prev_done;
      predict(frames, lines, timeout, amode, ard, e_trig, e_valid, e_el, e_et, e_abort, e_clean);
      trig = 0; valid = 0; rstc = 0; irqc = 0; since = 0; trig_smp = 0;
      et_smp = -1; done_smp = -1; busy_fall = -1; seen_busy = 1'b0; prev_done = tg_done;
      rsp_idx = 0;
      @(negedge clk); #1;
      cmd_frames = 8'(frames); cmd_lines = LINE_W'(lines); cmd_timeout = TO_W'(timeout);
      cmd_start = 1'b1;
      for (int n = 1; n <= 4000; n++) begin
         @(negedge clk); #1;
         cmd_start = 1'b0; cmd_abort = 1'b0;
         if (tg_trigger_o) begin
            trig++; since = 0; trig_smp = n;
            if (trig == FLUSH + 1) check("line_cnt_after_flush", line_cnt_o, plan_lines[FLUSH-1]);
         end else begin
            since++;
         end
         if (restart && trig == 1 && since == 3) begin
            cmd_start = 1'b1; cmd_frames = 8'd7;
            cmd_lines = LINE_W'($urandom_range(1, 40)); cmd_timeout = TO_W'(1);
         end
         if (frame_valid_o) begin
            check("frame_idx_pulse", frame_idx_o, valid);
            valid++;
         end
         if (tg_rst_o) rstc++;
         if (irq_o) irqc++;
         if (err_timeout_o && et_smp < 0) et_smp = n;
         if (tg_done && !prev_done) done_smp = n;
         prev_done = tg_done;
         if (amode == 1 && trig == ard + 1 && since == 20) cmd_abort = 1'b1;
         if (amode == 2 && trig == ard + 1 && done_smp == n) cmd_abort = 1'b1;
         if (busy_o) seen_busy = 1'b1;
         else if (seen_busy) begin
            busy_fall = n;
            break;
         end
      end
      check("capture_ends", busy_fall > 0, 1);
      check("trigger_count", trig, e_trig);
      check("frame_valid_count", valid, e_valid);
      check("err_lines", err_lines_o, e_el);
      check("err_timeout", err_timeout_o, e_et);
      check("tg_rst_cycles", rstc, (e_el | e_et | e_abort) ? RST_HOLD : 0);
      check("irq_count", irqc, 1);
      check("line_cnt_end", line_cnt_o, m_line);
      check("frame_idx_end", frame_idx_o, m_idx);
      // done edge is taken by the next posedge; CHECK and DONE follow, then busy drops
      if (e_clean) check("busy_after_done", busy_fall - done_smp, 3);
      if (e_et) check("timeout_latency", et_smp - trig_smp, ((timeout == 0) ? 1 : timeout) + 1);
      repeat (6) @(negedge clk);
   endtask

   initial begin
      int frames, lines, timeout, kind, n_rd, r, amode, ard;
      bit found;
      rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
      cmd_frames = 8'd0; cmd_lines = '0; cmd_timeout = '0;
      set_plan(3, 3, 3);
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", all_out, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      #1; cmd_abort = 1'b1;
      @(negedge clk); #1; cmd_abort = 1'b0;
      check("abort_in_idle", {busy_o, tg_rst_o, irq_o}, 0);

      set_plan(8, 8, 8);  run(2, 8, 1000, 0, 0, 1'b0);
      set_plan(5, 8, 8);  run(2, 8, 1000, 0, 0, 1'b0);
      set_plan(8, 7, 8);  run(2, 8, 1000, 0, 0, 1'b0);
      set_plan(8, 8, 8);  plan_done[0] = 1'b0; run(1, 8, 100, 0, 0, 1'b0);
      set_plan(6, 16, 8); run(1, 16, 1000, 1, 1, 1'b0);
      set_plan(6, 8, 8);  run(1, 8, 1000, 2, 1, 1'b0);
      set_plan(5, 6, 6);  run(0, 6, 1000, 0, 0, 1'b1);
      set_plan(4, 4, 4);  run(1, 4, 8, 0, 0, 1'b0);
      set_plan(4, 4, 4);  run(1, 4, 7, 0, 0, 1'b0);
      set_plan(4, 4, 4);  run(1, 4, 0, 0, 0, 1'b0);

      // rst in the middle of a readout wait
      set_plan(10, 10, 10);
      rsp_idx = 0; found = 1'b0;
      @(negedge clk); #1;
      cmd_frames = 8'd1; cmd_lines = LINE_W'(10); cmd_timeout = TO_W'(1000); cmd_start = 1'b1;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk); #1;
         cmd_start = 1'b0;
         if (tg_trigger_o) found = 1'b1;
      end
      check("rst_test_trigger_seen", found, 1);
      repeat (6) @(negedge clk);
      #1; rst = 1'b1; rsp_kill = 1'b1;
      @(negedge clk); #1;
      check("rst_mid_wait_outputs", all_out, 0);
      rst = 1'b0; rsp_kill = 1'b0; m_line = 0; m_idx = 0;
      repeat (3) @(negedge clk);

      for (int s = 0; s < 25; s++) begin
         frames = $urandom_range(0, 4);
         lines = $urandom_range(3, 12);
         n_rd = FLUSH + ((frames == 0) ? 1 : frames);
         set_plan(3, 3, 3);
         for (int i = 0; i < n_rd; i++) plan_lines[i] = (i < FLUSH) ? $urandom_range(3, 14) : lines;
         timeout = $urandom_range(64, 400);
         kind = $urandom_range(0, 4);
         r = $urandom_range(0, n_rd - 1);
         amode = 0; ard = 0;
         case (kind)
            1: plan_lines[(r < FLUSH) ? FLUSH : r] = lines + 1;
            2: begin
               plan_done[r] = 1'b0;
               timeout = $urandom_range(0, 60);
            end
            3: begin
               plan_lines[r] = 16;
               amode = 1; ard = r;
            end
            4: begin
               amode = 2; ard = r;
            end
            default: amode = 0;
         endcase
         run(frames, lines, timeout, amode, ard, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
